// File: rtl/spi_flash_arbiter_if.sv
// Pin bundle shared by the flash arbiter and whoever drives it.
// slave  : the arbiter's view (core/pass-thru/flash inputs in, muxed pins out).
// master : the surrounding system's view, exactly mirrored.
interface spi_flash_arbiter_if;
    // Management-core flash controller pins
    logic       core_csb;
    logic       core_sck;
    logic       core_io0;
    logic       core_io1;
    // Housekeeping SPI pass-thru pins and handshake
    logic       pt_req;
    logic       pt_csb;
    logic       pt_sck;
    logic       pt_sdi;
    logic       pt_sdo;
    logic       pt_grant;
    logic       core_hold;
    // Physical flash pins
    logic       flash_csb;
    logic       flash_clk;
    logic       flash_io0;
    logic       flash_io1;
    // Observability
    logic [2:0] arb_state;

    modport slave (
        input  core_csb, core_sck, core_io0, pt_req, pt_csb, pt_sck, pt_sdi, flash_io1,
        output core_io1, pt_sdo, pt_grant, core_hold, flash_csb, flash_clk, flash_io0, arb_state
    );

    modport master (
        output core_csb, core_sck, core_io0, pt_req, pt_csb, pt_sck, pt_sdi, flash_io1,
        input  core_io1, pt_sdo, pt_grant, core_hold, flash_csb, flash_clk, flash_io0, arb_state
    );
endinterface

// File: rtl/spi_flash_arbiter.sv
// Hands the SPI flash between the management core and the housekeeping
// pass-thru port. Ownership changes go CORE -> DRAIN -> GUARD_IN -> PASS ->
// GUARD_OUT -> CORE, with flash_csb held high for GUARD_CYCLES on each side.
// Optional feature macro: SPI_ARB_TIMEOUT_EN -- when defined, DRAIN preempts a
// core that keeps core_csb low for DRAIN_TIMEOUT cycles.
module spi_flash_arbiter #(
    parameter int GUARD_CYCLES  = 4,
    parameter int DRAIN_TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    spi_flash_arbiter_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_CORE      = 3'd0,
        ST_DRAIN     = 3'd1,
        ST_GUARD_IN  = 3'd2,
        ST_PASS      = 3'd3,
        ST_GUARD_OUT = 3'd4
    } state_t;

    localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] guard_cnt_q, guard_cnt_d;
    // Pin-mux selects are flops decoded from the next state so the muxes
    // never see decode glitches while the state register changes.
    logic       pass_sel_q, pass_sel_d;
    logic       force_q, force_d;
    logic       pt_grant_q, pt_grant_d;
    logic       core_hold_q, core_hold_d;
    logic       drain_expired;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_TIMEOUT - 1);

    logic [15:0] drain_cnt_q, drain_cnt_d;

    // Count cycles spent in DRAIN; held at zero everywhere else.
    always_comb begin
        drain_cnt_d = '0;
        if (state_q == ST_DRAIN) begin
            drain_cnt_d = drain_cnt_q + 16'd1;
        end
    end

    // DRAIN age register.
    always_ff @(posedge clk) begin
        if (reset) begin
            drain_cnt_q <= '0;
        end else begin
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign drain_expired = (state_q == ST_DRAIN) && (drain_cnt_q == DRAIN_LAST);
`else
    // Untimed build: DRAIN ends only on core_csb high or pt_req low. A limit
    // below one cycle would mean no wait at all, which is honoured here too.
    assign drain_expired = (DRAIN_TIMEOUT < 1);
`endif

    // State register plus guard counter and registered selects/outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CORE;
            guard_cnt_q <= '0;
            pass_sel_q  <= 1'b0;
            force_q     <= 1'b0;
            pt_grant_q  <= 1'b0;
            core_hold_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            guard_cnt_q <= guard_cnt_d;
            pass_sel_q  <= pass_sel_d;
            force_q     <= force_d;
            pt_grant_q  <= pt_grant_d;
            core_hold_q <= core_hold_d;
        end
    end

    // Next-state and guard-counter logic.
    always_comb begin
        state_d     = state_q;
        guard_cnt_d = guard_cnt_q;
        case (state_q)
            ST_CORE: begin
                if (bus.pt_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!bus.pt_req) begin
                    state_d = ST_CORE;
                end else if (bus.core_csb || drain_expired) begin
                    state_d     = ST_GUARD_IN;
                    guard_cnt_d = GUARD_LOAD;
                end
            end
            ST_GUARD_IN: begin
                if (!bus.pt_req) begin
                    state_d     = ST_GUARD_OUT;
                    guard_cnt_d = GUARD_LOAD;
                end else if (guard_cnt_q == 8'd0) begin
                    state_d = ST_PASS;
                end else begin
                    guard_cnt_d = guard_cnt_q - 8'd1;
                end
            end
            ST_PASS: begin
                if (!bus.pt_req) begin
                    state_d     = ST_GUARD_OUT;
                    guard_cnt_d = GUARD_LOAD;
                end
            end
            ST_GUARD_OUT: begin
                if (guard_cnt_q == 8'd0) begin
                    state_d = ST_CORE;
                end else begin
                    guard_cnt_d = guard_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d     = ST_CORE;
                guard_cnt_d = '0;
            end
        endcase
    end

    // Output decode from the next state, captured by the flops above.
    always_comb begin
        pass_sel_d  = (state_d == ST_PASS);
        force_d     = (state_d == ST_GUARD_IN) || (state_d == ST_GUARD_OUT);
        pt_grant_d  = (state_d == ST_PASS);
        core_hold_d = (state_d == ST_GUARD_IN) || (state_d == ST_PASS) ||
                      (state_d == ST_GUARD_OUT);
    end

    // Pin muxes: only data pins pass combinationally, selects are flops.
    assign bus.flash_csb = pass_sel_q ? bus.pt_csb : (force_q ? 1'b1 : bus.core_csb);
    assign bus.flash_clk = pass_sel_q ? bus.pt_sck : (force_q ? 1'b0 : bus.core_sck);
    assign bus.flash_io0 = pass_sel_q ? bus.pt_sdi : (force_q ? 1'b0 : bus.core_io0);
    assign bus.core_io1  = (!pass_sel_q && !force_q) ? bus.flash_io1 : 1'b0;
    assign bus.pt_sdo    = pass_sel_q ? bus.flash_io1 : 1'b0;
    assign bus.pt_grant  = pt_grant_q;
    assign bus.core_hold = core_hold_q;
    assign bus.arb_state = state_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Scoreboard bench for spi_flash_arbiter: every stimulus cycle pushes the
// expected ownership phase; a monitor pops it after the clock edge and checks
// state, handshakes and every muxed pin. Directed scenarios measure latencies
// and run a pass-thru flash read against a small flash model.
module tb_spi_flash_arbiter;

    localparam int G  = 4;
    localparam int DT = 8;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    localparam int P_CORE = 0, P_DRAIN = 1, P_GIN = 2, P_PASS = 3, P_GOUT = 4;

    logic clk = 1'b0;
    logic reset;
    spi_flash_arbiter_if bus();

    spi_flash_arbiter #(.GUARD_CYCLES(G), .DRAIN_TIMEOUT(DT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // ---------------- flash model (read command 0x03 returns 0x93,0x00) ---
    logic        use_model = 1'b0;
    logic        rnd_io1   = 1'b0;
    logic        model_io1 = 1'b0;
    logic [7:0]  cmd_sr    = 8'h00;
    logic [15:0] resp      = 16'h9300;
    int          rx_bits   = 0;

    assign bus.flash_io1 = use_model ? model_io1 : rnd_io1;

    always @(posedge bus.flash_clk) begin
        if (bus.flash_csb === 1'b0) begin
            if (rx_bits < 8) cmd_sr = {cmd_sr[6:0], bus.flash_io0};
            rx_bits = rx_bits + 1;
        end
    end

    always @(negedge bus.flash_clk) begin
        if (bus.flash_csb === 1'b0 && rx_bits >= 32 && rx_bits < 48 && cmd_sr == 8'h03)
            model_io1 = resp[47 - rx_bits];
    end

    always @(posedge bus.flash_csb) rx_bits = 0;

    // ---------------- reference model: phase + cycles spent in it --------
    int ph    = P_CORE;
    int spent = 1;
    int sb[$];

    function automatic void model_update();
        int nxt;
        if (reset) begin
            ph    = P_CORE;
            spent = 1;
            return;
        end
        nxt = ph;
        case (ph)
            P_CORE:  if (bus.pt_req) nxt = P_DRAIN;
            P_DRAIN: if (!bus.pt_req) nxt = P_CORE;
                     else if (bus.core_csb || (TO_ON && spent == DT)) nxt = P_GIN;
            P_GIN:   if (!bus.pt_req) nxt = P_GOUT;
                     else if (spent == G) nxt = P_PASS;
            P_PASS:  if (!bus.pt_req) nxt = P_GOUT;
            P_GOUT:  if (spent == G) nxt = P_CORE;
            default: nxt = P_CORE;
        endcase
        if (nxt != ph) spent = 1;
        else spent = spent + 1;
        ph = nxt;
    endfunction

    // One clock: predict the post-edge phase, queue it, then advance.
    task automatic step();
        model_update();
        sb.push_back(ph);
        @(posedge clk);
        #2;
    endtask

    // ---------------- monitor ---------------------------------------------
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (sb.size() != 0) begin
            int   e;
            logic [9:0] exp_v, got_v;
            logic csb, sck, io0, cio1, sdo;
            e = sb.pop_front();
            if (e == P_PASS) begin
                csb = bus.pt_csb; sck = bus.pt_sck; io0 = bus.pt_sdi;
                cio1 = 1'b0; sdo = bus.flash_io1;
            end else if (e == P_GIN || e == P_GOUT) begin
                csb = 1'b1; sck = 1'b0; io0 = 1'b0; cio1 = 1'b0; sdo = 1'b0;
            end else begin
                csb = bus.core_csb; sck = bus.core_sck; io0 = bus.core_io0;
                cio1 = bus.flash_io1; sdo = 1'b0;
            end
            exp_v = {3'(e), (e == P_PASS), (e >= P_GIN), csb, sck, io0, cio1, sdo};
            got_v = {bus.arb_state, bus.pt_grant, bus.core_hold, bus.flash_csb,
                     bus.flash_clk, bus.flash_io0, bus.core_io1, bus.pt_sdo};
            n_checks = n_checks + 1;
            if (got_v !== exp_v) begin
                n_fail = n_fail + 1;
                $display("FAIL scoreboard cyc=%0d {st,grant,hold,csb,clk,io0,cio1,sdo} got=%b required=%b",
                         cyc, got_v, exp_v);
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks = n_checks + 1;
        if (got != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    task automatic idle_core(input int n);
        bus.pt_req = 1'b0; bus.core_csb = 1'b1; bus.pt_csb = 1'b1;
        bus.pt_sck = 1'b0; bus.core_sck = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic enter_pass();
        idle_core(8);
        bus.pt_req = 1'b1;
        for (int i = 0; i < 7; i++) step();
    endtask

    // ---------------- stimulus --------------------------------------------
    initial begin
        int got;
        logic [31:0] cmd;
        logic [15:0] rd;

        reset = 1'b1;
        bus.core_csb = 1'b1; bus.core_sck = 1'b0; bus.core_io0 = 1'b0;
        bus.pt_req = 1'b0; bus.pt_csb = 1'b1; bus.pt_sck = 1'b0; bus.pt_sdi = 1'b0;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;
        idle_core(2);
        $display("[tb] reset sequence done");

        // Request from an idle core: PASS/grant six cycles after pt_req rises.
        bus.pt_req = 1'b1; bus.core_csb = 1'b1;
        got = -1;
        for (int i = 1; i <= 14; i++) begin
            step();
            if (i == 2) bus.core_csb = 1'b0;  // guard must still force csb high
            if (got < 0 && bus.pt_grant === 1'b1) got = i;
        end
        check("grant_latency", got, 6);
        check("pass_state", int'(bus.arb_state), P_PASS);
        $display("[tb] idle-core request granted after %0d cycles", got);

        // Pass-thru read 0x03 000000 -> expect 0x93 then 0x00 on pt_sdo.
        use_model = 1'b1; bus.core_csb = 1'b1;
        cmd = 32'h0300_0000; rd = '0;
        bus.pt_csb = 1'b0; step();
        for (int b = 0; b < 48; b++) begin
            bus.pt_sdi = (b < 32) ? cmd[31 - b] : 1'b0;
            bus.pt_sck = 1'b0; step();
            bus.pt_sck = 1'b1; step();
            if (b >= 32) rd = {rd[14:0], bus.pt_sdo};
        end
        bus.pt_sck = 1'b0; step();
        bus.pt_csb = 1'b1; step();
        use_model = 1'b0;
        check("read_byte0", int'(rd[15:8]), 8'h93);
        check("read_byte1", int'(rd[7:0]), 8'h00);
        $display("[tb] pass-thru read returned %h", rd);

        // Release: core_hold falls exactly five cycles after pt_req falls.
        bus.pt_req = 1'b0; bus.core_csb = 1'b0;
        got = -1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (got < 0 && bus.core_hold === 1'b0) got = i;
        end
        check("hold_release", got, 5);
        $display("[tb] release: core_hold dropped after %0d cycles", got);

        // Reset in the middle of PASS returns pins to the core at once.
        enter_pass();
        bus.core_csb = 1'b0; reset = 1'b1; step(); reset = 1'b0;
        check("reset_mid_pass_state", int'(bus.arb_state), P_CORE);
        check("reset_mid_pass_csb", int'(bus.flash_csb), 0);
        bus.pt_req = 1'b0; step();
        $display("[tb] reset during PASS handled");

        // Busy core: DRAIN waits for core_csb (or times out when enabled).
        idle_core(8);
        bus.core_csb = 1'b0; bus.pt_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.core_sck = ~bus.core_sck; bus.core_io0 = 1'($urandom);
            step();
        end
        bus.core_sck = 1'b0; bus.core_csb = 1'b1; step(); step();
        bus.pt_req = 1'b0; step();  // drop during GUARD_IN
        check("drop_in_guard_in", int'(bus.arb_state), P_GOUT);
        for (int i = 0; i < 6; i++) step();
        $display("[tb] busy-core drain and guard-in abort done");

        // Re-request held through GUARD_OUT still visits CORE first.
        enter_pass();
        bus.pt_req = 1'b0; step(); bus.pt_req = 1'b1;
        got = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.arb_state === 3'(P_CORE)) got = got + 1;
        end
        check("core_between_sessions", got, 1);
        $display("[tb] back-to-back request visited CORE %0d cycle(s)", got);

        // Long held core_csb=0: 1000 cycles of DRAIN unless timeout enabled.
        idle_core(8);
        bus.core_csb = 1'b0; bus.pt_req = 1'b1;
        for (int i = 0; i < 1000; i++) step();
        check("long_drain_state", int'(bus.arb_state), TO_ON ? P_PASS : P_DRAIN);
        bus.pt_req = 1'b0; step();
        $display("[tb] long drain done");
        idle_core(6);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) bus.pt_req = ~bus.pt_req;
            bus.core_csb = ($urandom_range(0, 3) != 0);
            bus.core_sck = 1'($urandom); bus.core_io0 = 1'($urandom);
            bus.pt_csb   = 1'($urandom); bus.pt_sck   = 1'($urandom);
            bus.pt_sdi   = 1'($urandom); rnd_io1      = 1'($urandom);
            reset        = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;
        idle_core(8);
        $display("[tb] random traffic done");

        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
